// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit.
// Lane math is expressed as a bit index so both endiannesses share one code path.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int MAX_BYTES = 8;

    function automatic int unsigned size_bytes(input size_t size);
        return 32'd1 << size;
    endfunction

    // Lowest bit index of the access field inside a data_w-wide word.
    function automatic int unsigned lane_base(input int unsigned offset,
                                              input size_t       size,
                                              input bit          big_endian,
                                              input int unsigned data_w);
        if (big_endian) begin
            return data_w - 8 * (offset + size_bytes(size));
        end
        return 8 * offset;
    endfunction

    function automatic logic [MAX_BYTES-1:0] be_mask(input int unsigned offset,
                                                     input size_t       size,
                                                     input bit          big_endian,
                                                     input int unsigned data_w);
        logic [MAX_BYTES-1:0] ones;
        ones = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < int'(size_bytes(size))) begin
                ones[i] = 1'b1;
            end
        end
        return ones << (lane_base(offset, size, big_endian, data_w) / 8);
    endfunction

endpackage

// File: rtl/lsu_mem_unit_extract.sv
// Load path: selects the addressed lanes of a memory word and sign/zero extends
// them to the full data width.
module lsu_extract
    import lsu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int BIG_ENDIAN = 1
) (
    input  logic [DATA_W-1:0]             rdata,
    input  logic [$clog2(DATA_W/8)-1:0]   offset,
    input  size_t                         size,
    input  logic                          is_unsigned,
    output logic [DATA_W-1:0]             data
);

    logic [31:0]       base;
    logic [DATA_W-1:0] shifted;
    int                nbits;
    logic              ext;

    always_comb begin
        base    = lane_base(32'(offset), size, BIG_ENDIAN != 0, DATA_W);
        shifted = rdata >> base;
        nbits   = 8 * int'(size_bytes(size));
        if (nbits > DATA_W) begin
            nbits = DATA_W;
        end
        // Full-width accesses never reach the extension bits, so unsigned is moot there.
        ext = !is_unsigned && shifted[nbits-1];
        for (int i = 0; i < DATA_W; i++) begin
            data[i] = (i < nbits) ? shifted[i] : ext;
        end
    end

endmodule

// File: rtl/lsu_mem_unit.sv
// Multicycle load/store unit between the core's request port and a req/ack memory.
// Optional ack watchdog enabled by defining LSU_TIMEOUT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | req_ready high, waiting for req_valid
// ST_ACCESS | mem_req high, memory outputs frozen until mem_ack
// ST_RESP   | resp_valid high, response held until resp_ready
module lsu_mem_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int BIG_ENDIAN = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int NBYTES = DATA_W / 8;
    localparam int OFF_W  = $clog2(NBYTES);

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    size_t                 size_q, size_d;
    logic                  uns_q, uns_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic                  req_ready_q, req_ready_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [NBYTES-1:0]     mem_be_q, mem_be_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]     resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;

    logic                  req_aligned;
    logic                  req_size_ok;
    logic [MAX_BYTES-1:0]  be_full;
    logic [DATA_W-1:0]     load_data;

`ifdef LSU_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0]            tmo_cnt_q, tmo_cnt_d;
`endif

    function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] wd,
                                                    input size_t             sz);
        int                nbits;
        logic [DATA_W-1:0] r;
        nbits = 8 * int'(size_bytes(sz));
        if (nbits > DATA_W) begin
            nbits = DATA_W;
        end
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = wd[i % nbits];
        end
        return r;
    endfunction

    always_comb begin
        case (size_t'(req_size))
            SZ_B:    req_aligned = 1'b1;
            SZ_H:    req_aligned = (req_addr[0] == 1'b0);
            SZ_W:    req_aligned = (req_addr[1:0] == 2'b00);
            default: req_aligned = (req_addr[2:0] == 3'b000);
        endcase
    end

    assign req_size_ok = !((DATA_W == 32) && (req_size == 2'd3));
    assign be_full     = be_mask(32'(req_addr[OFF_W-1:0]), size_t'(req_size),
                                 BIG_ENDIAN != 0, DATA_W);

    lsu_extract #(
        .DATA_W     (DATA_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_extract (
        .rdata       (mem_rdata),
        .offset      (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (load_data)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        req_ready_d  = req_ready_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
`ifdef LSU_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d        = req_we;
                    size_d      = size_t'(req_size);
                    uns_d       = req_unsigned;
                    off_d       = req_addr[OFF_W-1:0];
                    req_ready_d = 1'b0;
                    if (req_aligned && req_size_ok) begin
                        state_d     = ST_ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        mem_be_d    = be_full[NBYTES-1:0];
                        mem_wdata_d = req_we ? replicate(req_wdata, size_t'(req_size)) : '0;
`ifdef LSU_TIMEOUT_EN
                        tmo_cnt_d   = '0;
`endif
                    end else begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end
                end
            end

            ST_ACCESS: begin
                if (mem_ack) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = '0;
                    mem_be_d     = '0;
                    mem_wdata_d  = '0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = we_q ? '0 : load_data;
                end
`ifdef LSU_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = '0;
                    mem_be_d     = '0;
                    mem_wdata_d  = '0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end

            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            off_q        <= '0;
            req_ready_q  <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            req_ready_q  <= req_ready_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_unit.sv
// Bench for lsu_mem_unit: a 32-bit big-endian unit (index 0) and a 64-bit
// little-endian unit (index 1) checked against a byte-level reference model.
module tb_lsu_mem_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req_valid[2], req_we[2], req_unsigned[2], resp_ready[2], mem_ack[2];
    logic [1:0]  req_size[2];
    logic [31:0] req_addr[2];
    logic [63:0] req_wdata[2], mem_rdata[2];

    logic        req_ready[2], resp_valid[2], resp_err[2], mem_req[2], mem_we[2];
    logic [31:0] mem_addr[2];
    logic [7:0]  mem_be[2];
    logic [63:0] resp_rdata[2], mem_wdata[2];

    logic [31:0] rdata0, wdata0;
    logic [3:0]  be0;
    logic [63:0] rdata1, wdata1;
    logic [7:0]  be1;

    assign resp_rdata[0] = {32'h0, rdata0};
    assign mem_wdata[0]  = {32'h0, wdata0};
    assign mem_be[0]     = {4'h0, be0};
    assign resp_rdata[1] = rdata1;
    assign mem_wdata[1]  = wdata1;
    assign mem_be[1]     = be1;

    lsu_mem_unit #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1), .TIMEOUT(4)) u_dut32 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0][31:0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(rdata0), .resp_err(resp_err[0]), .mem_req(mem_req[0]), .mem_we(mem_we[0]),
        .mem_addr(mem_addr[0]), .mem_be(be0), .mem_wdata(wdata0), .mem_ack(mem_ack[0]),
        .mem_rdata(mem_rdata[0][31:0])
    );

    lsu_mem_unit #(.DATA_W(64), .ADDR_W(32), .BIG_ENDIAN(0), .TIMEOUT(255)) u_dut64 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(rdata1), .resp_err(resp_err[1]), .mem_req(mem_req[1]), .mem_we(mem_we[1]),
        .mem_addr(mem_addr[1]), .mem_be(be1), .mem_wdata(wdata1), .mem_ack(mem_ack[1]),
        .mem_rdata(mem_rdata[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          latency;
        int          mem_cycles;
        logic        valid;
        logic        err;
        logic        we;
        logic [63:0] rdata;
        logic [63:0] wdata;
        logic [31:0] addr;
        logic [7:0]  be;
        bit          stable;
        bit          idle_after;
    } obs_t;

    function automatic int dw_of(input int u);
        return (u == 0) ? 32 : 64;
    endfunction

    function automatic bit big_of(input int u);
        return (u == 0);
    endfunction

    function automatic bit model_illegal(input int u, input logic [31:0] addr, input int sz);
        int n;
        n = 1 << sz;
        return (dw_of(u) == 32 && sz == 3) || ((addr % n) != 0);
    endfunction

    // Gather the addressed bytes in memory order, assemble by endianness, then extend.
    function automatic logic [63:0] model_load(input int u, input logic [63:0] rd,
                                               input logic [31:0] addr, input int sz, input bit uns);
        int          nb, k, n, pos;
        logic [7:0]  b;
        logic [63:0] v;
        nb = dw_of(u) / 8;
        k  = int'(addr % nb);
        n  = 1 << sz;
        v  = 64'h0;
        for (int i = 0; i < n; i++) begin
            pos = k + i;
            if (big_of(u)) begin
                b = rd[(dw_of(u) - 1 - 8 * pos) -: 8];
                v = (v << 8) | {56'h0, b};
            end else begin
                b = rd[8 * pos +: 8];
                v = v | ({56'h0, b} << (8 * i));
            end
        end
        if (!uns && n < nb && v[8 * n - 1]) v = v | ({64{1'b1}} << (8 * n));
        if (dw_of(u) == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    function automatic logic [7:0] model_be(input int u, input logic [31:0] addr, input int sz);
        int         nb, k, n;
        logic [7:0] m;
        nb = dw_of(u) / 8;
        k  = int'(addr % nb);
        n  = 1 << sz;
        m  = 8'h0;
        for (int i = 0; i < n; i++) begin
            if (big_of(u)) m[nb - 1 - (k + i)] = 1'b1;
            else           m[k + i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [63:0] model_wdata(input int u, input logic [63:0] wd, input int sz);
        int          nb, n;
        logic [63:0] r;
        nb = dw_of(u) / 8;
        n  = 1 << sz;
        r  = 64'h0;
        for (int j = 0; j < nb; j++) r[8 * j +: 8] = wd[8 * (j % n) +: 8];
        return r;
    endfunction

    // Drives one request through to response acceptance and records what was seen.
    task automatic run_txn(input int u, input bit we, input int sz, input bit uns,
                           input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                           input int waits, input int hold, output obs_t o);
        int w;
        o = '{default: 0};
        o.stable = 1'b1;
        @(negedge clk);
        req_valid[u]    = 1'b1;
        req_we[u]       = we;
        req_size[u]     = 2'(sz);
        req_unsigned[u] = uns;
        req_addr[u]     = addr;
        req_wdata[u]    = wd;
        @(posedge clk); #1;
        req_valid[u]    = 1'b0;
        req_we[u]       = ~we;
        req_unsigned[u] = ~uns;
        req_size[u]     = 2'($urandom);
        req_addr[u]     = $urandom;
        req_wdata[u]    = {$urandom, $urandom};
        o.latency = 1;
        w = 0;
        while (resp_valid[u] !== 1'b1 && o.latency < 400) begin
            if (mem_req[u] === 1'b1) begin
                if (o.mem_cycles == 0) begin
                    o.addr  = mem_addr[u];
                    o.be    = mem_be[u];
                    o.wdata = mem_wdata[u];
                    o.we    = mem_we[u];
                end else if (mem_addr[u] !== o.addr || mem_be[u] !== o.be ||
                             mem_wdata[u] !== o.wdata || mem_we[u] !== o.we) begin
                    o.stable = 1'b0;
                end
                if (req_ready[u] !== 1'b0) o.stable = 1'b0;
                o.mem_cycles++;
                mem_ack[u]   = (w == waits);
                mem_rdata[u] = (w == waits) ? rd : {$urandom, $urandom};
                w++;
            end
            @(posedge clk); #1;
            mem_ack[u] = 1'b0;
            o.latency++;
        end
        o.valid = resp_valid[u];
        o.err   = resp_err[u];
        o.rdata = resp_rdata[u];
        for (int h = 0; h < hold; h++) begin
            mem_ack[u]   = 1'($urandom);
            mem_rdata[u] = {$urandom, $urandom};
            @(posedge clk); #1;
            if (resp_valid[u] !== 1'b1 || resp_rdata[u] !== o.rdata || resp_err[u] !== o.err ||
                req_ready[u] !== 1'b0 || mem_req[u] !== 1'b0) o.stable = 1'b0;
        end
        mem_ack[u]    = 1'b0;
        resp_ready[u] = 1'b1;
        @(posedge clk); #1;
        resp_ready[u] = 1'b0;
        o.idle_after = (req_ready[u] === 1'b1) && (resp_valid[u] === 1'b0);
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if ({req_ready[u], resp_valid[u], resp_err[u], mem_req[u], mem_we[u]} !== 5'b10000) begin
                n_fail++;
                $display("FAIL reset_ctrl u%0d: got %b want 10000", u,
                         {req_ready[u], resp_valid[u], resp_err[u], mem_req[u], mem_we[u]});
            end
            n_checks++;
            if ({mem_addr[u], mem_be[u], mem_wdata[u], resp_rdata[u]} !== '0) begin
                n_fail++;
                $display("FAIL reset_data u%0d: addr %h be %h wdata %h rdata %h want all 0", u,
                         mem_addr[u], mem_be[u], mem_wdata[u], resp_rdata[u]);
            end
        end
    endtask

    task automatic test_load_byte();
        obs_t o;
        run_txn(0, 1'b0, 0, 1'b0, 32'h1001, 64'h0, 64'h12F45678, 0, 0, o);
        n_checks++;
        if (o.valid !== 1'b1 || o.latency != 2) begin
            n_fail++;
            $display("FAIL lb_latency: valid %b latency %0d want 1 / 2", o.valid, o.latency);
        end
        n_checks++;
        if (o.rdata !== 64'hFFFF_FFF4 || o.err !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_signed: rdata %h err %b want fffffff4 / 0", o.rdata, o.err);
        end
        n_checks++;
        if (o.addr !== 32'h1000 || o.mem_cycles != 1 || o.we !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_mem: addr %h cycles %0d we %b want 1000 / 1 / 0", o.addr, o.mem_cycles, o.we);
        end
        run_txn(0, 1'b0, 0, 1'b1, 32'h1001, 64'h0, 64'h12F45678, 0, 0, o);
        n_checks++;
        if (o.rdata !== 64'h0000_00F4) begin
            n_fail++;
            $display("FAIL lbu: rdata %h want 000000f4", o.rdata);
        end
    endtask

    task automatic test_wait_states();
        obs_t o;
        run_txn(0, 1'b0, 1, 1'b0, 32'h1002, 64'h0, 64'h1234ABCD, 3, 0, o);
        n_checks++;
        if (o.mem_cycles != 4 || o.addr !== 32'h1000 || !o.stable) begin
            n_fail++;
            $display("FAIL lh_wait: cycles %0d addr %h stable %0d want 4 / 1000 / 1", o.mem_cycles, o.addr, o.stable);
        end
        n_checks++;
        if (o.rdata !== 64'hFFFF_ABCD || o.latency != 5) begin
            n_fail++;
            $display("FAIL lh_data: rdata %h latency %0d want ffffabcd / 5", o.rdata, o.latency);
        end
    endtask

    task automatic test_store();
        obs_t o;
        run_txn(0, 1'b1, 0, 1'b0, 32'h1003, 64'h0000_00A5, 64'hDEAD_BEEF, 1, 0, o);
        n_checks++;
        if (o.be !== 8'h01 || o.wdata !== 64'hA5A5_A5A5 || o.we !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_mem: be %h wdata %h we %b want 01 / a5a5a5a5 / 1", o.be, o.wdata, o.we);
        end
        n_checks++;
        if (o.rdata !== 64'h0 || o.err !== 1'b0 || o.valid !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_resp: rdata %h err %b valid %b want 0 / 0 / 1", o.rdata, o.err, o.valid);
        end
    endtask

    task automatic test_errors();
        obs_t o;
        run_txn(0, 1'b0, 2, 1'b0, 32'h1002, 64'h0, 64'h1111_2222, 0, 2, o);
        n_checks++;
        if (o.err !== 1'b1 || o.latency != 1 || o.mem_cycles != 0 || o.rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL lw_misaligned: err %b latency %0d cycles %0d rdata %h want 1 / 1 / 0 / 0",
                     o.err, o.latency, o.mem_cycles, o.rdata);
        end
        run_txn(0, 1'b0, 3, 1'b0, 32'h1000, 64'h0, 64'h1111_2222, 0, 0, o);
        n_checks++;
        if (o.err !== 1'b1 || o.mem_cycles != 0) begin
            n_fail++;
            $display("FAIL dword_on_32: err %b cycles %0d want 1 / 0", o.err, o.mem_cycles);
        end
        n_checks++;
        if (!o.idle_after) begin
            n_fail++;
            $display("FAIL err_release: idle_after %0d want 1", o.idle_after);
        end
    endtask

    task automatic test_dw64();
        obs_t o;
        run_txn(1, 1'b0, 2, 1'b1, 32'h4, 64'h0, 64'h89AB_CDEF_0000_0000, 0, 5, o);
        n_checks++;
        if (o.rdata !== 64'h0000_0000_89AB_CDEF || o.err !== 1'b0) begin
            n_fail++;
            $display("FAIL lwu_64: rdata %h err %b want 0000000089abcdef / 0", o.rdata, o.err);
        end
        n_checks++;
        if (!o.stable || !o.idle_after) begin
            n_fail++;
            $display("FAIL resp_hold_64: stable %0d idle_after %0d want 1 / 1", o.stable, o.idle_after);
        end
        run_txn(1, 1'b1, 1, 1'b0, 32'h6, 64'h0000_0000_0000_BEEF, 64'h0, 2, 0, o);
        n_checks++;
        if (o.be !== 8'hC0 || o.wdata !== 64'hBEEF_BEEF_BEEF_BEEF) begin
            n_fail++;
            $display("FAIL sh_64: be %h wdata %h want c0 / beefbeefbeefbeef", o.be, o.wdata);
        end
    endtask

    task automatic test_stray_ack();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_ack[0] = 1'b1;
            mem_ack[1] = 1'b1;
            @(posedge clk); #1;
            n_checks++;
            if (mem_req[0] !== 1'b0 || resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 ||
                mem_req[1] !== 1'b0 || resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_ack: mem_req %b%b resp_valid %b%b req_ready %b%b want 00 00 11",
                         mem_req[0], mem_req[1], resp_valid[0], resp_valid[1], req_ready[0], req_ready[1]);
            end
        end
        mem_ack[0] = 1'b0;
        mem_ack[1] = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = 2'd2;
        req_unsigned[0] = 1'b0; req_addr[0] = 32'h2000;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        n_checks++;
        if (mem_req[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_access_entry: mem_req %b want 1", mem_req[0]);
        end
        mem_ack[0]   = 1'b1;
        mem_rdata[0] = 64'h5555_AAAA;
        reset        = 1'b0;
        @(posedge clk); #1;
        mem_ack[0] = 1'b0;
        reset      = 1'b1;
        n_checks++;
        if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 || mem_req[0] !== 1'b0 || resp_rdata[0] !== 64'h0) begin
            n_fail++;
            $display("FAIL rst_mid_access: req_ready %b resp_valid %b mem_req %b rdata %h want 1 / 0 / 0 / 0",
                     req_ready[0], resp_valid[0], mem_req[0], resp_rdata[0]);
        end
        @(posedge clk); #1;
        n_checks++;
        if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ack_dropped: resp_valid %b req_ready %b want 0 / 1", resp_valid[0], req_ready[0]);
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        run_txn(0, 1'b0, 2, 1'b0, 32'h3000, 64'h0, 64'h0, 1000, 0, o);
        n_checks++;
        if (o.err !== 1'b1 || o.mem_cycles != 4 || o.rdata !== 64'h0 || o.latency != 5) begin
            n_fail++;
            $display("FAIL timeout: err %b cycles %0d rdata %h latency %0d want 1 / 4 / 0 / 5",
                     o.err, o.mem_cycles, o.rdata, o.latency);
        end
    endtask
`endif

    task automatic test_random();
        obs_t        o;
        int          u, sz, waits, hold, n;
        bit          we, uns, bad;
        logic [31:0] addr;
        logic [63:0] wd, rd, exp_rd;
        for (int t = 0; t < 80; t++) begin
            u     = t % 2;
            sz    = $urandom_range(0, 3);
            n     = 1 << sz;
            we    = 1'($urandom);
            uns   = 1'($urandom);
            addr  = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(n) - 32'd1);
            wd    = {$urandom, $urandom};
            rd    = {$urandom, $urandom};
            if (u == 0) rd[63:32] = 32'h0;
            waits = $urandom_range(0, 3);
            hold  = $urandom_range(0, 2);
            bad   = model_illegal(u, addr, sz);
            exp_rd = (bad || we) ? 64'h0 : model_load(u, rd, addr, sz, uns);
            run_txn(u, we, sz, uns, addr, wd, rd, waits, hold, o);
            n_checks++;
            if (o.valid !== 1'b1 || o.latency != (bad ? 1 : waits + 2) || o.mem_cycles != (bad ? 0 : waits + 1)) begin
                n_fail++;
                $display("FAIL rnd_timing t%0d: valid %b latency %0d cycles %0d want 1 / %0d / %0d",
                         t, o.valid, o.latency, o.mem_cycles, bad ? 1 : waits + 2, bad ? 0 : waits + 1);
            end
            n_checks++;
            if (o.err !== bad || o.rdata !== exp_rd) begin
                n_fail++;
                $display("FAIL rnd_resp t%0d u%0d sz%0d addr %h: err %b rdata %h want %b / %h",
                         t, u, sz, addr, o.err, o.rdata, bad, exp_rd);
            end
            n_checks++;
            if (!o.stable || !o.idle_after) begin
                n_fail++;
                $display("FAIL rnd_hold t%0d: stable %0d idle_after %0d want 1 / 1", t, o.stable, o.idle_after);
            end
            if (!bad) begin
                n_checks++;
                if (o.addr !== (addr & ~(32'(dw_of(u) / 8) - 32'd1)) || o.we !== we) begin
                    n_fail++;
                    $display("FAIL rnd_addr t%0d: addr %h we %b want %h / %b", t, o.addr, o.we,
                             addr & ~(32'(dw_of(u) / 8) - 32'd1), we);
                end
                if (we) begin
                    n_checks++;
                    if (o.be !== model_be(u, addr, sz) || o.wdata !== model_wdata(u, wd, sz)) begin
                        n_fail++;
                        $display("FAIL rnd_store t%0d u%0d sz%0d: be %h wdata %h want %h / %h", t, u, sz,
                                 o.be, o.wdata, model_be(u, addr, sz), model_wdata(u, wd, sz));
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_we[u] = 1'b0; req_unsigned[u] = 1'b0; req_size[u] = 2'd0;
            req_addr[u] = 32'h0; req_wdata[u] = 64'h0; resp_ready[u] = 1'b0;
            mem_ack[u] = 1'b0; mem_rdata[u] = 64'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        test_stray_ack();
        test_load_byte();
        test_wait_states();
        test_store();
        test_errors();
        test_dw64();
        test_reset_mid_access();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_unit.md
Name: lsu_mem_unit

Overview:
Parametrised multicycle load/store unit for the MIPS core, generalising the byte-load path to byte, halfword, word and (64-bit) doubleword accesses, both signed and unsigned. Stores produce lane-replicated data and byte enables. Sits between the ALU-out/B registers and the memory port. Uses a valid/ready request from the controller, a req/ack memory handshake that tolerates wait states, and a held response.

Parameters:
DATA_W, 32, memory data width; 32 or 64.
ADDR_W, 32, byte address width.
BIG_ENDIAN, 1, 1 means byte offset 0 sits in the MSB lane; 0 means it sits in the LSB lane.
TIMEOUT, 255, maximum cycles to wait for mem_ack (used only with LSU_TIMEOUT_EN).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
req_valid  in  1  access request
req_ready  out  1  unit idle, can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
req_unsigned  in  1  zero-extend loads (LBU/LHU/LWU)
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-justified
resp_valid  out  1  response held until accepted
resp_ready  in  1  controller accepts the response
resp_rdata  out  DATA_W  extended load data; 0 for stores
resp_err  out  1  misaligned, illegal size, or timeout
mem_req  out  1  memory access active
mem_we  out  1  memory write
mem_addr  out  ADDR_W  address aligned down to DATA_W/8
mem_be  out  DATA_W/8  byte enables
mem_wdata  out  DATA_W  lane-replicated store data
mem_ack  in  1  memory completes the access (read data valid this cycle)
mem_rdata  in  DATA_W  read data

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- req_ready = (state == IDLE).
- Handshake fires when req_valid && req_ready. On a fire, the unit latches we, size, unsigned, addr and wdata.
- Legal request (aligned, size legal) -> ACCESS. Otherwise -> RESP with resp_err = 1 and no memory cycle.
- Alignment rule: addr mod 2^size == 0.
- Illegal size: size 3 when DATA_W = 32.
- ACCESS: mem_req = 1. mem_we, mem_addr, mem_be and mem_wdata are held stable until mem_ack.
- On mem_ack: the extracted load is registered into resp_rdata, resp_err = 0, -> RESP.
- RESP: resp_valid = 1, and resp_rdata/resp_err are held. resp_valid && resp_ready -> IDLE.
- A new request is accepted no earlier than the cycle after RESP exits (no bypass).
- Minimum latency: request accepted in cycle T; mem_req high in T+1; with ack in T+1, resp_valid is high in T+2.
- Lane rule: for byte offset k = addr mod (DATA_W/8), the lane is bits [DATA_W-1-8k -: 8] if BIG_ENDIAN, else [8k +: 8].
- Half/word/dword accesses take the 2/4/8 contiguous lanes starting at offset k, in the same endianness.
- Load extension:
  - sign-extend from the access MSB unless unsigned;
  - size == DATA_W/8 ignores req_unsigned.
- Store:
  - mem_wdata = the low 8·2^size bits of wdata replicated across all lanes;
  - mem_be marks only the addressed lanes;
  - resp_rdata = 0.
- mem_ack outside ACCESS is ignored.
- Reset (reset == 0 at a clock edge, from any state, including mid-access) -> IDLE. All outputs are 0 after reset except req_ready = 1. An in-flight ack is dropped.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - a counter clears on ACCESS entry and increments each ACCESS cycle without mem_ack;
  - when it reaches TIMEOUT: deassert mem_req, go to RESP with resp_err = 1 and resp_rdata = 0.
- Undefined: no counter; ACCESS waits for mem_ack indefinitely.

Decomposition:
- Package lsu_pkg holds:
  - the size_t enum (SZ_B, SZ_H, SZ_W, SZ_D);
  - the state_t enum;
  - a lane_base function (offset, size, BIG_ENDIAN) giving the bit index;
  - a be_mask function.
- One sub-module, lsu_extract: combinational lane select plus sign/zero extension for loads, parametrised by DATA_W and BIG_ENDIAN. Instantiated once.

Test Plan:
- DATA_W = 32, BIG_ENDIAN = 1, load byte signed, addr 0x1001, mem_rdata 0x12F45678, ack in T+1 -> resp_rdata 0xFFFFFFF4, resp_valid in T+2. Same request unsigned -> 0x000000F4.
- Load half at addr 0x1002, mem_rdata 0x1234ABCD, 3 wait states -> mem_req held 4 cycles with mem_addr 0x1000; resp_rdata 0xFFFFABCD.
- Store byte at 0x1003, wdata 0x000000A5 -> mem_be 0001, mem_wdata 0xA5A5A5A5, mem_we = 1, resp_rdata 0.
- Load word at 0x1002 -> resp_err = 1 in T+1, no mem_req ever. DATA_W = 32 with size 3 -> resp_err = 1.
- DATA_W = 64, BIG_ENDIAN = 0, load word unsigned at 0x4, mem_rdata 0x89ABCDEF_00000000 -> resp_rdata 0x0000000089ABCDEF. resp_ready held low 5 cycles -> rdata stable and req_ready = 0 throughout.
- Reset low during ACCESS with ack in the same cycle -> IDLE next cycle, resp_valid = 0, req_ready = 1. With LSU_TIMEOUT_EN and TIMEOUT = 4, no ack -> resp_err = 1 after 4 ACCESS cycles.
